gpio_config_loader: RTL

//   Sequences the GPIO configuration shift chain. On request it fetches one CFG_W-bit config word
//   per pad from the housekeeping register file and shifts all words serially into the chain of
//   per-pad GPIO control blocks, then pulses serial_load to commit them. On a separate request it

---
 rtl/gpio_cfg_pkg.sv | 25 ++
 rtl/gpio_serial_phase.sv | 41 ++++
 rtl/gpio_config_loader.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/gpio_cfg_pkg.sv
// Shared types and constants for the GPIO configuration chain loader.
package gpio_cfg_pkg;

    localparam int NUM_GPIO_DEF = 38;
    localparam int CFG_W_DEF    = 10;
    localparam int CLK_DIV_DEF  = 4;

    // Loader sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_SHIFT     = 3'd2,
        ST_LOAD      = 3'd3,
        ST_CHAIN_RST = 3'd4,
        ST_FINISH    = 3'd5
    } state_t;

    // Counter width for a range of n values; a single-entry range still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IDX_W = idx_width(NUM_GPIO_DEF);

endpackage

// File: rtl/gpio_serial_phase.sv
// Bit-period timer for the serial chain: serial_clock is low for the first
// CLK_DIV cycles of each bit and high for the last CLK_DIV; bit_end marks the
// final cycle of a bit. Both stay idle (clock low, counter zero) while run=0.
module gpio_serial_phase
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic serial_clock,
    output logic bit_end
);

    localparam int PW = $clog2(2 * CLK_DIV);
    localparam logic [PW-1:0] RISE_AT = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] LAST_AT = PW'(2 * CLK_DIV - 1);

    logic [PW-1:0] cnt_q;

    assign bit_end = run && (cnt_q == LAST_AT);

    // Phase counter and registered serial clock; clock rises mid-bit, falls at bit end.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            cnt_q        <= '0;
            serial_clock <= 1'b0;
        end else begin
            if (bit_end) begin
                cnt_q        <= '0;
                serial_clock <= 1'b0;
            end else begin
                cnt_q <= cnt_q + PW'(1);
                if (cnt_q == RISE_AT) begin
                    serial_clock <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/gpio_config_loader.sv
// Sequences the GPIO configuration shift chain: fetches one word per pad from
// the register file, shifts them out highest pad first / MSB first, then pulses
// serial_load. A separate request holds serial_resetn low so every pad reverts
// to its tie-cell defaults.
//
// Handshake: xfer_start and defaults_req are single-cycle request pulses that
// are only accepted in IDLE (busy=0); while busy they are dropped, never queued.
// defaults_req wins if both arrive together. done pulses for one cycle as busy
// falls.
module gpio_config_loader
    import gpio_cfg_pkg::*;
#(
    parameter int NUM_GPIO = NUM_GPIO_DEF,
    parameter int CFG_W    = CFG_W_DEF,
    parameter int CLK_DIV  = CLK_DIV_DEF
) (
    input  logic                               wb_clk_i,
    input  logic                               wb_rst_i,
    input  logic                               xfer_start,
    input  logic                               defaults_req,
    output logic [idx_width(NUM_GPIO)-1:0]     cfg_idx,
    input  logic [CFG_W-1:0]                   cfg_word,
    output logic                               serial_clock,
    output logic                               serial_data,
    output logic                               serial_load,
    output logic                               serial_resetn,
    output logic                               busy,
    output logic                               done,
    output state_t                             dbg_state
);

    localparam int IW = idx_width(NUM_GPIO);
    localparam int BW = idx_width(CFG_W);
    localparam int PW = $clog2(2 * CLK_DIV);
    localparam logic [IW-1:0] IDX_TOP   = IW'(NUM_GPIO - 1);
    localparam logic [BW-1:0] BIT_TOP   = BW'(CFG_W - 1);
    localparam logic [PW-1:0] HOLD_LAST = PW'(2 * CLK_DIV - 1);

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [CFG_W-1:0] shreg_q, shreg_d;
    logic [PW-1:0]    hold_q, hold_d;
    logic             sdata_q, sdata_d;
    logic             load_q, load_d;
    logic             resetn_q, resetn_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             bit_end;

    gpio_serial_phase #(
        .CLK_DIV (CLK_DIV)
    ) u_phase (
        .clk          (wb_clk_i),
        .rst          (wb_rst_i),
        .run          (state_q == ST_SHIFT),
        .serial_clock (serial_clock),
        .bit_end      (bit_end)
    );

    // State and output registers; reset aborts any operation with no load and no done.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= ST_IDLE;
            idx_q    <= IDX_TOP;
            bit_q    <= '0;
            shreg_q  <= '0;
            hold_q   <= '0;
            sdata_q  <= 1'b0;
            load_q   <= 1'b0;
            resetn_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            hold_q   <= hold_d;
            sdata_q  <= sdata_d;
            load_q   <= load_d;
            resetn_q <= resetn_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        hold_d   = hold_q;
        sdata_d  = sdata_q;
        load_d   = 1'b0;
        resetn_d = 1'b1;
        busy_d   = busy_q;
        done_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                sdata_d = 1'b0;
                busy_d  = 1'b0;
                if (defaults_req) begin
                    state_d  = ST_CHAIN_RST;
                    resetn_d = 1'b0;
                    hold_d   = '0;
                    busy_d   = 1'b1;
                end else if (xfer_start) begin
                    state_d = ST_FETCH;
                    idx_d   = IDX_TOP;
                    busy_d  = 1'b1;
                end
            end
            ST_FETCH: begin
                shreg_d = cfg_word;
                sdata_d = cfg_word[CFG_W-1];
                bit_d   = BIT_TOP;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (bit_end) begin
                    if (bit_q == '0) begin
                        sdata_d = 1'b0;
                        if (idx_q == '0) begin
                            state_d = ST_LOAD;
                            load_d  = 1'b1;
                            hold_d  = '0;
                        end else begin
                            idx_d   = idx_q - IW'(1);
                            state_d = ST_FETCH;
                        end
                    end else begin
                        shreg_d = shreg_q << 1;
                        sdata_d = shreg_q[CFG_W-2];
                        bit_d   = bit_q - BW'(1);
                    end
                end
            end
            ST_LOAD: begin
                load_d = 1'b1;
                hold_d = hold_q + PW'(1);
                if (hold_q == HOLD_LAST) begin
                    load_d  = 1'b0;
                    state_d = ST_FINISH;
                end
            end
            ST_CHAIN_RST: begin
                resetn_d = 1'b0;
                hold_d   = hold_q + PW'(1);
                if (hold_q == HOLD_LAST) begin
                    resetn_d = 1'b1;
                    state_d  = ST_FINISH;
                end
            end
            ST_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cfg_idx       = idx_q;
    assign serial_data   = sdata_q;
    assign serial_load   = load_q;
    assign serial_resetn = resetn_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign dbg_state     = state_q;

endmodule
